// File: rtl/softmax_out_writer.sv
// softmax_out_writer
// ------------------
// Write-back engine for the softmax output lanes. It collects LANES elements
// per input beat, packs NUM elements into one memory word (element 0 in the
// LSBs) and writes the words to consecutive RAM addresses, from start_addr_i
// through end_addr_i. The address wraps modulo 2^ADDRSIZE.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   init_i       synchronous clear back to IDLE (beats start_i)
//   start_i      one-cycle pulse that loads the addresses and begins a run
//   start_addr_i first word address, sampled on start_i
//   end_addr_i   last word address, sampled on start_i
//   in_valid_i   input beat qualifier
//   in_data_i    LANES elements, lane k at [k*DATAWIDTH +: DATAWIDTH]
//   flush_i      write the partial word with its unfilled slots set to zero
//   wr_en_o      registered RAM write strobe
//   wr_addr_o    registered RAM write address
//   wr_data_o    registered RAM write data
//   busy_o       high while collecting (COLLECT)
//   done_o       high once the last word has been written (DONE)
//   drop_o       one-cycle pulse when a valid beat is discarded
module softmax_out_writer #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 8,
  parameter int LANES     = 4,
  parameter int ADDRSIZE  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      init_i,
  input  logic                      start_i,
  input  logic [ADDRSIZE-1:0]       start_addr_i,
  input  logic [ADDRSIZE-1:0]       end_addr_i,
  input  logic                      in_valid_i,
  input  logic [LANES*DATAWIDTH-1:0] in_data_i,
  input  logic                      flush_i,
  output logic                      wr_en_o,
  output logic [ADDRSIZE-1:0]       wr_addr_o,
  output logic [DATAWIDTH*NUM-1:0]  wr_data_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      drop_o
);

  localparam int BEATS  = NUM / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_W = DATAWIDTH * NUM;
  localparam int BEAT_W = DATAWIDTH * LANES;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  state_e              state_q;
  logic [ADDRSIZE-1:0] cur_addr_q;
  logic [ADDRSIZE-1:0] last_addr_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [WORD_W-1:0]   pack_q;
  logic [WORD_W-1:0]   pack_d;
  logic                wr_en_q;
  logic [ADDRSIZE-1:0] wr_addr_q;
  logic [WORD_W-1:0]   wr_data_q;
  logic                drop_q;

  logic                last_beat;
  logic                do_write;
  logic [WORD_W-1:0]   write_word;

  // Pack the current beat into its slots and decide whether this cycle
  // closes a word. A word closes on the final beat, on flush together with a
  // beat, or on a bare flush once at least one beat is held. A bare flush
  // writes the register as-is, since its unfilled slots are already zero.
  always_comb begin
    pack_d     = pack_q;
    pack_d[int'(beat_cnt_q) * BEAT_W +: BEAT_W] = in_data_i;
    last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
    do_write   = 1'b0;
    write_word = pack_d;
    if (state_q == COLLECT && !start_i && !init_i) begin
      if (in_valid_i) begin
        do_write = last_beat || flush_i;
      end else if (flush_i && beat_cnt_q != '0) begin
        do_write   = 1'b1;
        write_word = pack_q;
      end
    end
  end

  // Single FSM register block. Priority is init, then start, then normal
  // operation. start from any state reloads the addresses and throws away
  // any partial word. A beat arriving outside COLLECT, or together with
  // start, is reported on drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      beat_cnt_q  <= '0;
      pack_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      drop_q  <= 1'b0;
      if (init_i) begin
        state_q    <= IDLE;
        beat_cnt_q <= '0;
        pack_q     <= '0;
        wr_addr_q  <= '0;
        wr_data_q  <= '0;
      end else if (start_i) begin
        state_q     <= COLLECT;
        cur_addr_q  <= start_addr_i;
        last_addr_q <= end_addr_i;
        beat_cnt_q  <= '0;
        pack_q      <= '0;
        drop_q      <= in_valid_i;
      end else begin
        case (state_q)
          COLLECT: begin
            if (do_write) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= cur_addr_q;
              wr_data_q  <= write_word;
              beat_cnt_q <= '0;
              pack_q     <= '0;
              if (cur_addr_q == last_addr_q) begin
                state_q <= DONE;
              end else begin
                cur_addr_q <= cur_addr_q + ADDRSIZE'(1);
              end
            end else if (in_valid_i) begin
              pack_q     <= pack_d;
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            drop_q <= in_valid_i;
          end
        endcase
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign drop_o    = drop_q;
  assign busy_o    = (state_q == COLLECT);
  assign done_o    = (state_q == DONE);

endmodule
